frame_fetcher: RTL and testbench

// Requester-side client of the 2-channel memory bus arbiter. On start, reads LENGTH

---
 rtl/frame_fetcher.sv | 176 +++++++++++++++++
 tb/tb_frame_fetcher.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fetcher.sv
// Fetches LENGTH words from frame memory over one arbiter channel and streams them
// out through a small FIFO on a valid/ready pixel interface.
module frame_fetcher #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     data_req,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_rdy,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [LW-1:0] LEN_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_FINISH,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [LW-1:0]            length_q, length_d;
  logic [LW-1:0]            issued_q, issued_d;
  logic                     req_q, req_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic [DATA_WIDTH-1:0]    fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]            wrPtr_q, rdPtr_q;
  logic [CW-1:0]            count_q;

  logic                     fifoWr;
  logic                     fifoRd;
  logic                     fifoValid;
  logic                     hasRoom;
  logic [ADDRESS_WIDTH-1:0] nextAddr;

  assign fifoValid = (count_q != CNT_ZERO);
  assign fifoRd    = fifoValid && pix_ready;
  assign hasRoom   = (count_q < DEPTH_C);
  assign nextAddr  = base_q + issued_q[ADDRESS_WIDTH-1:0];

  // RELEASE may re-issue directly so an uncontested word costs 4 cycles total
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    length_d = length_q;
    issued_d = issued_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fifoWr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          length_d = length;
          issued_d = LEN_ZERO;
          state_d  = (length == LEN_ZERO) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hasRoom) begin
          req_d   = 1'b1;
          addr_d  = nextAddr;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_rdy) begin
          fifoWr   = 1'b1;
          issued_d = issued_q + LEN_ONE;
          req_d    = 1'b0;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (issued_q == length_q) begin
          state_d = S_FINISH;
        end else if (hasRoom) begin
          req_d   = 1'b1;
          addr_d  = nextAddr;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        if (!fifoValid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      length_q <= '0;
      issued_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      length_q <= length_d;
      issued_q <= issued_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
    end
  end

  // Storage needs no reset: pix_data is gated by pix_valid
  always_ff @(posedge clk) begin
    if (fifoWr) begin
      fifoMem_q[wrPtr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (fifoWr) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (fifoRd) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      case ({fifoWr, fifoRd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign data_req  = req_q;
  assign data_addr = addr_q;
  assign pix_valid = fifoValid;
  assign pix_data  = fifoValid ? fifoMem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_frame_fetcher.sv
// Bench for frame_fetcher: models the arbiter and frame memory, runs a table of
// fetches plus hand-written corner sequences, and checks against computed values.
module tb_frame_fetcher;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic       data_req;
  logic [7:0] data_addr;
  logic [7:0] data_in;
  logic       data_rdy;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  int checks = 0;
  int errors = 0;

  frame_fetcher #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .data_req(data_req),
    .data_addr(data_addr),
    .data_in(data_in),
    .data_rdy(data_rdy),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memWord(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Arbiter model: rdy rises grantDelay edges after req is seen, clears once req drops
  int grantDelay = 2;
  int waitCnt    = 0;
  initial begin
    data_rdy = 1'b0;
    data_in  = '0;
  end
  always @(posedge clk) begin
    if (!data_req) begin
      data_rdy <= 1'b0;
      waitCnt  <= 0;
    end else if (!data_rdy) begin
      if (waitCnt + 1 >= grantDelay) begin
        data_rdy <= 1'b1;
        data_in  <= memWord(data_addr);
      end
      waitCnt <= waitCnt + 1;
    end
  end

  // Monitor sampled on the falling edge, away from DUT updates
  logic [7:0] reqAddrs[$];
  int         reqCycles[$];
  int         reqLens[$];
  logic [7:0] pixOut[$];
  int         cycle = 0;
  int         curLen = 0;
  int         doneCnt = 0;
  int         addrViol = 0;
  int         pixViol = 0;
  int         reqRdyViol = 0;
  logic       prevReq = 1'b0;
  logic [7:0] prevAddr = '0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData = '0;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      prevReq   = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (data_req && !prevReq) begin
        reqAddrs.push_back(data_addr);
        reqCycles.push_back(cycle);
        curLen = 0;
        if (data_rdy) reqRdyViol++;
      end
      if (data_req) curLen++;
      if (!data_req && prevReq) reqLens.push_back(curLen);
      if (data_req && prevReq && data_addr != prevAddr) addrViol++;
      if (pix_valid && pix_ready) pixOut.push_back(pix_data);
      if (prevValid && !prevReady && (!pix_valid || pix_data != prevData)) pixViol++;
      if (done) doneCnt++;
      prevReq   = data_req;
      prevValid = pix_valid;
    end
    prevAddr  = data_addr;
    prevReady = pix_ready;
    prevData  = pix_data;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic clearLogs();
    reqAddrs.delete();
    reqCycles.delete();
    reqLens.delete();
    pixOut.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int budget, input string name);
    int n = 0;
    while (doneCnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (doneCnt == d0) checkOutput({name, " done timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    int         holdCycles;
    int         expStalled;
    int         expWords;
    logic [7:0] expFirst;
    logic [7:0] expLast;
    int         expPeriod;
  } vec_t;

  vec_t vecs[4];

  task automatic runVector(input int idx, input vec_t v);
    int d0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    clearLogs();
    pix_ready = (v.holdCycles == 0);
    d0 = doneCnt;
    applyStimulus(v.base, v.len);
    if (v.holdCycles > 0) begin
      repeat (v.holdCycles) @(posedge clk);
      #1;
      checkOutput({tag, " stalled req count"}, reqAddrs.size(), v.expStalled);
      checkOutput({tag, " stalled data_req"}, int'(data_req), 0);
      checkOutput({tag, " stalled pix_valid"}, int'(pix_valid), 1);
      pix_ready = 1'b1;
    end
    waitDone(d0, int'(v.len) * 8 + 100, tag);
    #1;
    checkOutput({tag, " busy after done"}, int'(busy), 0);
    checkOutput({tag, " done pulses"}, doneCnt - d0, 1);
    checkOutput({tag, " request count"}, reqAddrs.size(), v.expWords);
    checkOutput({tag, " pixel count"}, pixOut.size(), v.expWords);
    if (reqAddrs.size() > 0) begin
      checkOutput({tag, " first addr"}, reqAddrs[0], v.expFirst);
      checkOutput({tag, " last addr"}, reqAddrs[reqAddrs.size()-1], v.expLast);
    end
    for (int i = 0; i < reqAddrs.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), reqAddrs[i], 8'(v.base + i));
    end
    for (int i = 0; i < pixOut.size(); i++) begin
      checkOutput($sformatf("%s pix[%0d]", tag, i), pixOut[i], memWord(8'(v.base + i)));
    end
    if (v.expPeriod != 0) begin
      for (int i = 1; i < reqCycles.size(); i++) begin
        checkOutput($sformatf("%s req period[%0d]", tag, i), reqCycles[i] - reqCycles[i-1],
                    v.expPeriod);
      end
    end
  endtask

  initial begin
    int d0;
    int n;

    vecs[0] = '{base: 8'h10, len: 9'd4,   holdCycles: 0,  expStalled: 0, expWords: 4,
                expFirst: 8'h10, expLast: 8'h13, expPeriod: 4};
    vecs[1] = '{base: 8'h20, len: 9'd8,   holdCycles: 40, expStalled: 4, expWords: 8,
                expFirst: 8'h20, expLast: 8'h27, expPeriod: 0};
    vecs[2] = '{base: 8'hFE, len: 9'd4,   holdCycles: 0,  expStalled: 0, expWords: 4,
                expFirst: 8'hFE, expLast: 8'h01, expPeriod: 4};
    vecs[3] = '{base: 8'h80, len: 9'd256, holdCycles: 0,  expStalled: 0, expWords: 256,
                expFirst: 8'h80, expLast: 8'h7F, expPeriod: 4};

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset data_req", int'(data_req), 0);
    checkOutput("reset data_addr", int'(data_addr), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset pix_valid", int'(pix_valid), 0);
    checkOutput("reset pix_data", int'(pix_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      runVector(i, vecs[i]);
    end

    // Zero-length fetch, plus a start that coincides with the done pulse
    clearLogs();
    d0 = doneCnt;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 8'h55;
    length    = 9'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("len0 busy c1", int'(busy), 1);
    checkOutput("len0 done c1", int'(done), 0);
    @(negedge clk);
    checkOutput("len0 busy c2", int'(busy), 1);
    checkOutput("len0 done c2", int'(done), 1);
    #1;
    start     = 1'b1;
    base_addr = 8'h66;
    length    = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("len0 busy c3", int'(busy), 0);
    checkOutput("len0 done c3", int'(done), 0);
    @(negedge clk);
    checkOutput("start-at-done ignored", int'(busy), 0);
    @(posedge clk);
    checkOutput("len0 no requests", reqAddrs.size(), 0);
    checkOutput("len0 done pulses", doneCnt - d0, 1);

    // Contended grant: long rdy latency, extra start mid-fetch must be ignored
    clearLogs();
    grantDelay = 10;
    pix_ready  = 1'b1;
    n = addrViol;
    d0 = doneCnt;
    applyStimulus(8'h30, 9'd2);
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 8'h99;
    length    = 9'd5;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(d0, 200, "contention");
    #1;
    checkOutput("contention req count", reqAddrs.size(), 2);
    if (reqAddrs.size() == 2) begin
      checkOutput("contention addr0", reqAddrs[0], 8'h30);
      checkOutput("contention addr1", reqAddrs[1], 8'h31);
    end
    checkOutput("contention req lens", reqLens.size(), 2);
    for (int i = 0; i < reqLens.size(); i++) begin
      checkOutput($sformatf("contention req hold[%0d]", i), reqLens[i], 11);
    end
    checkOutput("contention pix count", pixOut.size(), 2);
    if (pixOut.size() == 2) begin
      checkOutput("contention pix0", pixOut[0], memWord(8'h30));
      checkOutput("contention pix1", pixOut[1], memWord(8'h31));
    end
    checkOutput("contention addr stable", addrViol - n, 0);
    checkOutput("contention done pulses", doneCnt - d0, 1);
    grantDelay = 2;

    // Reset while waiting for the second grant, then a clean fetch
    clearLogs();
    pix_ready = 1'b0;
    applyStimulus(8'h50, 9'd4);
    n = 0;
    while (reqAddrs.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rst-test second request seen", int'(reqAddrs.size() >= 2), 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("after rst data_req", int'(data_req), 0);
    checkOutput("after rst pix_valid", int'(pix_valid), 0);
    checkOutput("after rst busy", int'(busy), 0);
    @(posedge clk);
    #1;
    clearLogs();
    pix_ready = 1'b1;
    d0 = doneCnt;
    applyStimulus(8'h40, 9'd2);
    waitDone(d0, 100, "post-rst");
    #1;
    checkOutput("post-rst req count", reqAddrs.size(), 2);
    checkOutput("post-rst pix count", pixOut.size(), 2);
    if (reqAddrs.size() == 2 && pixOut.size() == 2) begin
      checkOutput("post-rst addr0", reqAddrs[0], 8'h40);
      checkOutput("post-rst addr1", reqAddrs[1], 8'h41);
      checkOutput("post-rst pix0", pixOut[0], memWord(8'h40));
      checkOutput("post-rst pix1", pixOut[1], memWord(8'h41));
    end
    checkOutput("post-rst busy", int'(busy), 0);

    checkOutput("global addr stability", addrViol, 0);
    checkOutput("global pix stability", pixViol, 0);
    checkOutput("global req while rdy", reqRdyViol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
